// File: rtl/frame_thr_pkg.sv
// Shared types and the grade-to-threshold mapping for frame_threshold_ctrl.
package frame_thr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HOLD   = 2'd1,
      ST_REPEAT = 2'd2,
      ST_LOCK   = 2'd3
   } key_state_t;

   // base + grade*step, saturated to the all-ones value of a thr_w-bit threshold
   function automatic int unsigned thr_map(input int unsigned grade,
                                           input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned thr_w);
      int unsigned sum;
      int unsigned sat_max;
      sum     = base + grade * step;
      sat_max = (32'd1 << thr_w) - 32'd1;
      return (sum > sat_max) ? sat_max : sum;
   endfunction

endpackage

// File: rtl/frame_threshold_ctrl_key_debounce.sv
// Raw key synchroniser and debouncer; emits the debounced level and a one-cycle rising-edge pulse.
module key_debounce #(
   parameter int DEBOUNCE_CYC = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic level,
   output logic rise
);

   localparam int CW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(DEBOUNCE_CYC - 1);

   logic          sync1;
   logic          sync2;
   logic          armed;
   logic [CW-1:0] cnt;

   // Synchroniser resets to "pressed": a key held through reset must first be
   // seen released for a full debounce window before it is armed again.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         armed <= 1'b0;
         level <= 1'b0;
         rise  <= 1'b0;
         cnt   <= CNT_LOAD;
      end else begin
         sync1 <= key;
         sync2 <= sync1;
         rise  <= 1'b0;
         if (!armed) begin
            if (sync2) begin
               cnt <= CNT_LOAD;
            end else if (cnt == '0) begin
               armed <= 1'b1;
               cnt   <= CNT_LOAD;
            end else begin
               cnt <= cnt - 1'b1;
            end
         end else if (sync2 == level) begin
            cnt <= CNT_LOAD;
         end else if (cnt == '0) begin
            level <= sync2;
            rise  <= sync2;
            cnt   <= CNT_LOAD;
         end else begin
            cnt <= cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/frame_threshold_ctrl.sv
// Key-driven grade/threshold controller; threshold is applied only at frame_start.
// Long-press auto-repeat is built only when FRAME_THR_AUTOREPEAT_EN is defined.
module frame_threshold_ctrl
   import frame_thr_pkg::*;
#(
   parameter int GRADE_W       = 4,
   parameter int NUM_GRADES    = 16,
   parameter int THRESH_W      = 8,
   parameter int THRESH_BASE   = 5,
   parameter int THRESH_STEP   = 5,
   parameter int RESET_GRADE   = 2,
   parameter int WRAP          = 1,
   parameter int DEBOUNCE_CYC  = 1_000_000,
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                key_add,
   input  logic                key_sub,
   input  logic                frame_start,
   output logic [GRADE_W-1:0]  frame_grade,
   output logic [THRESH_W-1:0] frame_threshold,
   output logic                grade_changed
);

   localparam logic [GRADE_W-1:0]  GRADE_MAX = GRADE_W'(NUM_GRADES - 1);
   localparam logic [GRADE_W-1:0]  GRADE_RST = GRADE_W'(RESET_GRADE);
   localparam logic [THRESH_W-1:0] THR_RST   =
      THRESH_W'(thr_map(RESET_GRADE, THRESH_BASE, THRESH_STEP, THRESH_W));

   logic add_lvl, add_rise, sub_lvl, sub_rise;

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_add (
      .clk(clk), .rst(rst), .key(key_add), .level(add_lvl), .rise(add_rise)
   );

   key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_sub (
      .clk(clk), .rst(rst), .key(key_sub), .level(sub_lvl), .rise(sub_rise)
   );

   key_state_t state, state_nxt;
   logic       held_sub, held_sub_nxt;
   logic       step_add, step_sub;
   logic       held_lvl, other_lvl;

`ifdef FRAME_THR_AUTOREPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
   localparam logic [REP_W-1:0] DELAY_LD  = REP_W'(REPEAT_DELAY - 1);
   localparam logic [REP_W-1:0] PERIOD_LD = REP_W'(REPEAT_PERIOD - 1);
   logic [REP_W-1:0] rep_cnt, rep_cnt_nxt;
`endif

   assign held_lvl  = held_sub ? sub_lvl : add_lvl;
   assign other_lvl = held_sub ? add_lvl : sub_lvl;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         held_sub <= 1'b0;
`ifdef FRAME_THR_AUTOREPEAT_EN
         rep_cnt  <= '0;
`endif
      end else begin
         state    <= state_nxt;
         held_sub <= held_sub_nxt;
`ifdef FRAME_THR_AUTOREPEAT_EN
         rep_cnt  <= rep_cnt_nxt;
`endif
      end
   end

   always_comb begin
      state_nxt    = state;
      held_sub_nxt = held_sub;
      step_add     = 1'b0;
      step_sub     = 1'b0;
`ifdef FRAME_THR_AUTOREPEAT_EN
      rep_cnt_nxt  = rep_cnt;
`endif
      case (state)
         ST_IDLE: begin
            if (add_rise && sub_rise) begin
               state_nxt = ST_LOCK;
            end else if (add_rise || sub_rise) begin
               step_add     = add_rise;
               step_sub     = sub_rise;
               held_sub_nxt = sub_rise;
               state_nxt    = ST_HOLD;
`ifdef FRAME_THR_AUTOREPEAT_EN
               rep_cnt_nxt  = DELAY_LD;
`endif
            end
         end
         ST_HOLD, ST_REPEAT: begin
            // Release wins over a repeat step that falls due in the same cycle.
            if (other_lvl) begin
               state_nxt = ST_LOCK;
            end else if (!held_lvl) begin
               state_nxt = ST_IDLE;
`ifdef FRAME_THR_AUTOREPEAT_EN
            end else if (rep_cnt == '0) begin
               step_add    = !held_sub;
               step_sub    = held_sub;
               state_nxt   = ST_REPEAT;
               rep_cnt_nxt = PERIOD_LD;
            end else begin
               rep_cnt_nxt = rep_cnt - 1'b1;
`endif
            end
         end
         ST_LOCK: begin
            if (!add_lvl && !sub_lvl) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   logic [GRADE_W-1:0]  grade_nxt;
   logic [THRESH_W-1:0] pending;

   always_comb begin
      grade_nxt = frame_grade;
      if (step_add) begin
         if (frame_grade == GRADE_MAX) grade_nxt = (WRAP != 0) ? '0 : frame_grade;
         else                          grade_nxt = frame_grade + GRADE_W'(1);
      end else if (step_sub) begin
         if (frame_grade == '0) grade_nxt = (WRAP != 0) ? GRADE_MAX : frame_grade;
         else                   grade_nxt = frame_grade - GRADE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_grade     <= GRADE_RST;
         grade_changed   <= 1'b0;
         pending         <= THR_RST;
         frame_threshold <= THR_RST;
      end else begin
         frame_grade   <= grade_nxt;
         grade_changed <= (grade_nxt != frame_grade);
         pending       <= THRESH_W'(thr_map(32'(frame_grade), THRESH_BASE, THRESH_STEP, THRESH_W));
         if (frame_start) frame_threshold <= pending;
      end
   end

endmodule

// File: tb/tb_frame_threshold_ctrl.sv
// Directed bench for frame_threshold_ctrl: a wrapping and a saturating instance share the keys.
module tb_frame_threshold_ctrl;

`ifdef FRAME_THR_AUTOREPEAT_EN
   localparam int HOLD_STEPS = 5;
`else
   localparam int HOLD_STEPS = 1;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       key_add;
   logic       key_sub;
   logic       frame_start;
   logic [3:0] grade_w, grade_s;
   logic [7:0] thr_w, thr_s;
   logic       chg_w, chg_s;

   int nerr = 0;
   int nchk = 0;
   int pulses_w = 0;
   int pulses_s = 0;
   int pw0, ps0;

   always #5 clk = ~clk;

   frame_threshold_ctrl #(
      .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .WRAP(1)
   ) dut (
      .clk(clk), .rst(rst), .key_add(key_add), .key_sub(key_sub),
      .frame_start(frame_start), .frame_grade(grade_w),
      .frame_threshold(thr_w), .grade_changed(chg_w)
   );

   frame_threshold_ctrl #(
      .DEBOUNCE_CYC(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(5), .WRAP(0)
   ) dut_sat (
      .clk(clk), .rst(rst), .key_add(key_add), .key_sub(key_sub),
      .frame_start(frame_start), .frame_grade(grade_s),
      .frame_threshold(thr_s), .grade_changed(chg_s)
   );

   always @(posedge clk) begin
      if (chg_w === 1'b1) pulses_w++;
      if (chg_s === 1'b1) pulses_s++;
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp)
      else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press(input bit sub);
      if (sub) key_sub = 1'b1; else key_add = 1'b1;
      cyc(10);
      key_add = 1'b0;
      key_sub = 1'b0;
      cyc(12);
   endtask

   task automatic frame();
      frame_start = 1'b1;
      cyc(1);
      frame_start = 1'b0;
      cyc(1);
   endtask

   initial begin
      rst = 1'b1; key_add = 1'b0; key_sub = 1'b0; frame_start = 1'b0;
      cyc(3);
      rst = 1'b0;
      chk("reset_grade", grade_w, 2);
      chk("reset_thr", thr_w, 15);
      chk("reset_chg", chg_w, 0);
      chk("reset_grade_sat", grade_s, 2);
      cyc(20);

      // clean press: debounced edge 6 edges after the raw edge, grade one edge later
      pw0 = pulses_w;
      key_add = 1'b1;
      cyc(6);
      chk("clean_chg_early", chg_w, 0);
      cyc(1);
      chk("clean_chg_pulse", chg_w, 1);
      chk("clean_grade", grade_w, 3);
      cyc(1);
      chk("clean_chg_end", chg_w, 0);
      cyc(2);
      chk("clean_thr_before_frame", thr_w, 15);
      frame();
      chk("clean_thr_after_frame", thr_w, 20);
      key_add = 1'b0;
      cyc(12);
      chk("clean_pulse_count", pulses_w - pw0, 1);

      // glitches shorter than the debounce window
      pw0 = pulses_w;
      key_add = 1'b1; cyc(2); key_add = 1'b0; cyc(2);
      key_add = 1'b1; cyc(2); key_add = 1'b0; cyc(2);
      key_add = 1'b1;
      cyc(6);
      chk("glitch_chg_early", chg_w, 0);
      cyc(1);
      chk("glitch_chg_pulse", chg_w, 1);
      chk("glitch_grade", grade_w, 4);
      key_add = 1'b0;
      cyc(12);
      chk("glitch_pulse_count", pulses_w - pw0, 1);

      // top end: wrap versus saturate
      repeat (11) press(0);
      chk("top_grade_w", grade_w, 15);
      chk("top_grade_s", grade_s, 15);
      pw0 = pulses_w; ps0 = pulses_s;
      press(0);
      chk("wrap_add_grade", grade_w, 0);
      chk("sat_add_grade", grade_s, 15);
      chk("wrap_add_pulses", pulses_w - pw0, 1);
      chk("sat_add_pulses", pulses_s - ps0, 0);
      frame();
      chk("wrap_thr", thr_w, 5);
      chk("sat_thr", thr_s, 80);

      // bottom end
      press(1);
      chk("wrap_sub_grade", grade_w, 15);
      chk("sat_sub_grade", grade_s, 14);
      repeat (14) press(1);
      chk("bottom_grade_w", grade_w, 1);
      chk("bottom_grade_s", grade_s, 0);
      ps0 = pulses_s;
      press(1);
      chk("sat_sub0_grade", grade_s, 0);
      chk("sat_sub0_pulses", pulses_s - ps0, 0);
      chk("wrap_sub_to0", grade_w, 0);

      // long press of 40 debounced cycles
      pw0 = pulses_w;
      key_add = 1'b1;
      cyc(40);
      key_add = 1'b0;
      cyc(15);
      chk("hold_pulses", pulses_w - pw0, HOLD_STEPS);
      chk("hold_grade_w", grade_w, HOLD_STEPS);
      chk("hold_grade_s", grade_s, HOLD_STEPS);
      frame();
      chk("hold_thr", thr_w, 5 + 5 * HOLD_STEPS);

      // both keys together
      pw0 = pulses_w;
      key_add = 1'b1; key_sub = 1'b1;
      cyc(15);
      key_add = 1'b0; key_sub = 1'b0;
      cyc(12);
      chk("both_pulses", pulses_w - pw0, 0);
      chk("both_grade", grade_w, HOLD_STEPS);

      // add held, then sub pressed: locked until both released
      pw0 = pulses_w;
      key_add = 1'b1;
      cyc(10);
      key_sub = 1'b1;
      cyc(30);
      key_sub = 1'b0;
      cyc(15);
      chk("lock_grade_held", grade_w, HOLD_STEPS + 1);
      key_add = 1'b0;
      cyc(12);
      chk("lock_pulses", pulses_w - pw0, 1);
      press(0);
      chk("after_lock_grade", grade_w, HOLD_STEPS + 2);

      // reset while a key is mid-debounce and still held
      key_add = 1'b1;
      cyc(3);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      chk("rst_mid_grade", grade_w, 2);
      chk("rst_mid_thr", thr_w, 15);
      pw0 = pulses_w;
      cyc(30);
      chk("rst_held_pulses", pulses_w - pw0, 0);
      chk("rst_held_grade", grade_w, 2);
      key_add = 1'b0;
      cyc(12);
      press(0);
      chk("rst_rearm_grade", grade_w, 3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/frame_threshold_ctrl.md
# frame_threshold_ctrl

Parametrised key-driven threshold controller for the frame-difference pipeline. Two raw push-button inputs are synchronised and debounced, then step a grade index with optional long-press auto-repeat. The grade maps arithmetically to a difference threshold, which is applied to the datapath only at frame boundaries so a frame is never binarised with two thresholds. It sits between the board keys and the frame-difference binarisation stage.

## Interface
- GRADE_W, 4, grade index width
- NUM_GRADES, 16, number of grades (2..2^GRADE_W); valid grades 0..NUM_GRADES-1
- THRESH_W, 8, threshold width
- THRESH_BASE, 5, threshold at grade 0
- THRESH_STEP, 5, threshold increment per grade
- RESET_GRADE, 2, grade after reset
- WRAP, 1, 1: wrap at ends; 0: saturate at ends
- DEBOUNCE_CYC, 1_000_000, stable cycles required to accept a key level change (10 ms @ 100 MHz)
- REPEAT_DELAY, 50_000_000, hold cycles before first auto-repeat
- REPEAT_PERIOD, 10_000_000, cycles between auto-repeat steps
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- key_add  in  1  raw key, active-high, asynchronous to clk
- key_sub  in  1  raw key, active-high, asynchronous to clk
- frame_start  in  1  one-cycle pulse at start of each frame (vsync rising edge)
- frame_grade  out  GRADE_W  current grade
- frame_threshold  out  THRESH_W  threshold applied to the datapath
- grade_changed  out  1  one-cycle pulse on every grade update

## Operation
- Per key: 2-flop synchroniser, then debounce counter; debounced level changes only after the synchronised input differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the counter.
- Step event: one-cycle pulse on the debounced rising edge (plus auto-repeat pulses, see Configuration).
- Key FSM: IDLE, HOLD, REPEAT, LOCK.
  - IDLE: exactly one debounced key rises -> issue step, go HOLD, clear hold counter. Both rise the same cycle -> LOCK, no step.
  - HOLD/REPEAT: held key released -> IDLE. Other key becomes pressed -> LOCK, no step.
  - LOCK: no steps; go IDLE when both keys are released.
- Grade update: add at NUM_GRADES-1 -> 0 (WRAP=1) or hold (WRAP=0); sub at 0 -> NUM_GRADES-1 or hold. grade_changed pulses only if the value actually changed.
- Pending threshold = THRESH_BASE + grade*THRESH_STEP, computed at THRESH_W+GRADE_W bits, saturated to 2^THRESH_W-1. Every grade maps; no holes.
- frame_threshold loads the pending value on frame_start only.

## Timing
- Reset values: frame_grade = RESET_GRADE; pending and frame_threshold = map(RESET_GRADE) (15 with defaults); grade_changed = 0; FSM IDLE; debounced levels 0.
- Raw edge -> debounced edge: 2 + DEBOUNCE_CYC cycles. Step pulse registered at the debounced edge; frame_grade and grade_changed update on the next edge; pending threshold one cycle after that.
- frame_threshold updates on the clock edge where frame_start is high, using the pending register value at that edge. A grade change landing in the same cycle is applied at the following frame_start.
- Reset mid-hold or mid-debounce: all counters clear; a key still held after reset must be released and debounced before it can step again.

## Configuration
- FRAME_THR_AUTOREPEAT_EN defined: in HOLD, after REPEAT_DELAY cycles issue a step and go REPEAT; in REPEAT, issue a step every REPEAT_PERIOD cycles while held.
- Not defined: HOLD never times out; one step per press; REPEAT state and repeat counter are not synthesised.

## Structure
- Package frame_thr_pkg: key FSM state enum, and the constant function mapping grade to threshold with saturation.
- Sub-module key_debounce (synchroniser + debounce counter + rising-edge pulse), instantiated once per key.

## Test plan
Test plan uses DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=5, defaults otherwise.
- Reset -> frame_grade=2, frame_threshold=15, grade_changed=0.
- Clean key_add press; frame_start after 10 cycles -> grade 3, one grade_changed pulse, threshold 20 only after frame_start.
- key_add with 2-cycle glitches before a stable level -> exactly one step, at 2+4 cycles after the last bounce.
- Grade 15: add -> 0, threshold 5 (WRAP=1); with WRAP=0 -> stays 15, no grade_changed. Grade 0: sub -> 15 / stays 0.
- key_add held 40 cycles with macro defined -> steps at press, +20, +25, +30, +35; without macro -> single step.
- Both keys pressed together -> LOCK, no change. Add held, sub pressed -> no further steps until both released.
